seq_tx: RTL and testbench

SEQ_TX -- requirements
Module: seq_tx

---
 rtl/seq_tx_pkg.sv | 21 ++
 rtl/seq_tx_piso_shift.sv | 27 ++
 rtl/seq_tx.sv | 98 +++++++++
 tb/tb_seq_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial framed transmitter and its far-end recognizer.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } tx_state_t;

  localparam logic [2:0] PREAMBLE     = 3'b110;
  localparam int         PREAMBLE_LEN = 3;

  // The counter also indexes the preamble, so it needs at least 2 bits even for tiny payloads.
  function automatic int cnt_width(input int dw);
    int w;
    w = $clog2(dw) + 1;
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/seq_tx_piso_shift.sv
// Parallel-in serial-out payload shifter: parallel load, shift left, MSB presented on msb.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/seq_tx.sv
// Framed serial transmitter: accepts a word in IDLE, sends preamble 1,1,0 then the payload MSB first.
module seq_tx
  import seq_tx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              out,
  output logic              busy,
  output logic              done,
  output tx_state_t         s
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  tx_state_t        s_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             out_next;
  logic             load, shift, msb;

  piso_shift #(.W(DATA_W)) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (data),
    .msb   (msb)
  );

  // out is registered, so each branch computes the bit to be shown in the coming cycle.
  always_comb begin
    s_next   = s;
    cnt_next = cnt;
    out_next = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    case (s)
      IDLE: begin
        if (valid) begin
          s_next   = PRE;
          cnt_next = '0;
          out_next = PREAMBLE[PREAMBLE_LEN-1];
          load     = 1'b1;
        end
      end
      PRE: begin
        if (cnt == PRE_LAST) begin
          s_next   = DATA;
          cnt_next = '0;
          out_next = msb;
          shift    = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
          out_next = PREAMBLE[2'(PREAMBLE_LEN - 2 - int'(cnt))];
        end
      end
      DATA: begin
        if (cnt == DATA_LAST) begin
          s_next   = DONE;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + 1'b1;
          out_next = msb;
          shift    = 1'b1;
        end
      end
      DONE: begin
        s_next = IDLE;
      end
      default: begin
        s_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s   <= IDLE;
      cnt <= '0;
      out <= 1'b0;
    end else begin
      s   <= s_next;
      cnt <= cnt_next;
      out <= out_next;
    end
  end

  assign ready = (s == IDLE);
  assign busy  = (s != IDLE);
  assign done  = (s == DONE);

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: frame contents, back-to-back gap, mid-frame reset and input isolation.
module tb_seq_tx;
  import seq_tx_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       valid;
  logic       ready, out, busy, done;
  tx_state_t  s;

  int n_chk  = 0;
  int n_fail = 0;
  logic [0:0] exp_q[$];

  // Far-end 1,1,0 recognizer model, S0..S3.
  logic [1:0] rec, rec_nx;

  seq_tx #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .s     (s)
  );

  always #5 clk = ~clk;

  always_comb begin
    rec_nx = 2'd0;
    case (rec)
      2'd0: rec_nx = out ? 2'd1 : 2'd0;
      2'd1: rec_nx = out ? 2'd2 : 2'd0;
      2'd2: rec_nx = out ? 2'd2 : 2'd3;
      2'd3: rec_nx = out ? 2'd1 : 2'd0;
      default: rec_nx = 2'd0;
    endcase
  end

  always @(posedge clk or posedge reset) begin
    if (reset) rec <= 2'd0;
    else       rec <= rec_nx;
  end

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_s"},     16'(s), 16'(IDLE));
    chk({tag, "_out"},   16'(out), 16'd0);
    chk({tag, "_ready"}, 16'(ready), 16'd1);
    chk({tag, "_busy"},  16'(busy), 16'd0);
    chk({tag, "_done"},  16'(done), 16'd0);
  endtask

  task automatic push_frame(input logic [7:0] w);
    logic [10:0] f;
    f = {3'b110, w};
    for (int i = 10; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  // Called on the first frame cycle; returns positioned on the IDLE cycle after DONE.
  task automatic drain(input string tag, input bit scramble);
    for (int i = 0; i < 11; i++) begin
      chk({tag, "_out"},  16'(out), 16'(exp_q.pop_front()));
      chk({tag, "_busy"}, 16'(busy), 16'd1);
      chk({tag, "_done"}, 16'(done), 16'd0);
      if (i < 3) chk({tag, "_rec"}, 16'(rec_nx), 16'(i + 1));
      if (scramble) begin
        valid = 1'($urandom_range(0, 1));
        data  = 8'($urandom_range(0, 255));
      end
      tick();
    end
    chk({tag, "_done_s"},   16'(s), 16'(DONE));
    chk({tag, "_done_out"}, 16'(out), 16'd0);
    chk({tag, "_done_pls"}, 16'(done), 16'd1);
    chk({tag, "_done_rdy"}, 16'(ready), 16'd0);
    tick();
    if (scramble) valid = 1'b0;
    chk({tag, "_end_s"},   16'(s), 16'(IDLE));
    chk({tag, "_end_out"}, 16'(out), 16'd0);
    chk({tag, "_end_rdy"}, 16'(ready), 16'd1);
    chk({tag, "_end_don"}, 16'(done), 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    #1;
    idle_checks("rst0");
    tick(); idle_checks("rst1");
    tick(); idle_checks("rst2");
    // valid during reset must not be taken.
    valid = 1'b1;
    data  = 8'hA5;
    tick(); idle_checks("rst_valid");

    // First edge after release accepts the word.
    reset = 1'b0;
    push_frame(8'hA5);
    tick();
    valid = 1'b0;
    drain("a5", 1'b0);

    tick();
    data  = 8'h00;
    valid = 1'b1;
    push_frame(8'h00);
    tick();
    valid = 1'b0;
    drain("z00", 1'b0);

    // valid held high: FF then 0F, two zero cycles between frames.
    data  = 8'hFF;
    valid = 1'b1;
    push_frame(8'hFF);
    tick();
    data = 8'h0F;
    drain("ff", 1'b0);
    push_frame(8'h0F);
    tick();
    valid = 1'b0;
    drain("0f", 1'b0);

    // Mid-frame reset during the 5th DATA cycle.
    tick();
    data  = 8'h96;
    valid = 1'b1;
    push_frame(8'h96);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("abort_out", 16'(out), 16'(exp_q.pop_front()));
      tick();
    end
    chk("abort_pre_s", 16'(s), 16'(DATA));
    #2 reset = 1'b1;
    #1;
    idle_checks("abort");
    exp_q.delete();
    tick(); idle_checks("abort_hold");
    reset = 1'b0;
    data  = 8'h3C;
    valid = 1'b1;
    push_frame(8'h3C);
    tick();
    valid = 1'b0;
    drain("3c", 1'b0);

    // Inputs churn during a frame; captured word must be sent.
    tick();
    data  = 8'h5A;
    valid = 1'b1;
    push_frame(8'h5A);
    tick();
    drain("hold", 1'b1);
    tick(); idle_checks("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
